cmos_axis_pack: RTL and testbench
=================================

CMOS_AXIS_PACK -- requirements
Module: cmos_axis_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries; power of two, 4..64.
REQ-002 SHALL have parameter WIDTH_BITS, default 12, width of the pixel and line counters.
REQ-003 SHALL have port cmos_pclk_i, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port hs_i, input, 1: line-active strobe from the decode stage.
REQ-006 SHALL have port vs_i, input, 1: frame sync, high during vertical blanking.
REQ-007 SHALL have port rgb565_i, input, 16: pixel data.
REQ-008 SHALL have port ce_i, input, 1: pixel-qualify enable.
REQ-009 SHALL have port m_axis_tdata, output, 16: stream pixel.
REQ-010 SHALL have port m_axis_tvalid, output, 1: FIFO non-empty.
REQ-011 SHALL have port m_axis_tready, input, 1: sink ready.
REQ-012 SHALL have port m_axis_tuser, output, 1: start of frame, first pixel only.
REQ-013 SHALL have port m_axis_tlast, output, 1: last pixel of a line.
REQ-014 SHALL have port overflow_o, output, 1: sticky FIFO-overflow flag.
REQ-015 SHALL have port line_width_o, output, WIDTH_BITS: pixel count of the last completed line.
REQ-016 SHALL have port line_count_o, output, WIDTH_BITS: line count of the last completed frame.

Function
REQ-017 SHALL treat a clock with ce_i=1 and hs_i=1 as a pixel event; all other cycles carry no pixel.
REQ-018 SHALL register hs_i and vs_i once (hs_d, vs_d).
REQ-019 SHALL detect line end when hs_d=1 and hs_i=0, frame start when vs_d=1 and vs_i=0, and frame end when vs_d=0 and vs_i=1.
REQ-020 SHALL hold each pixel in a one-entry hold register (data, sof bit, valid).
REQ-021 SHALL push the held pixel to the FIFO with tlast=0 when the next pixel event occurs, then load the new pixel into the hold register.
REQ-022 SHALL push the held pixel with tlast=1 on line end and clear hold valid; with hold empty, line end pushes nothing.
REQ-023 SHALL give pixel latency of two clocks minimum from pixel event to m_axis_tvalid, or two clocks after line end for the last pixel of a line.
REQ-024 SHALL set sof_pending on frame start and copy it into the hold sof bit on the next pixel event, then clear sof_pending.
REQ-025 SHALL accept a FIFO write when count<FIFO_DEPTH or a pop occurs in the same cycle.
REQ-026 SHALL pop the FIFO when m_axis_tvalid=1 and m_axis_tready=1; m_axis_tdata, tuser and tlast SHALL be the FIFO head, stable while tvalid=1 and tready=0.
REQ-027 SHALL, on a rejected write: drop the pixel, set overflow_o=1 (sticky until reset), and enter DROP state.
REQ-028 SHALL use states RUN and DROP: DROP discards all pixel events and pushes, the hold register is cleared, and DROP exits to RUN on frame start.
REQ-029 SHALL count pixel events per line in a WIDTH_BITS counter, saturating at all-ones.
REQ-030 SHALL, on line end with a nonzero counter, load the counter into line_width_o, increment the line counter (saturating) and clear the pixel counter.
REQ-031 SHALL, on frame end, load the line counter into line_count_o and clear it.
REQ-032 SHALL, when line end and frame end occur in the same cycle, count that line in the ending frame.
REQ-033 SHALL, when frame start arrives while the hold register is valid, discard the held pixel (no push) and not count it.
REQ-034 SHALL count pixels and lines in DROP state, so the geometry outputs stay valid.

Reset
REQ-035 SHALL, while rst_n_i=0, clear FIFO pointers, hold register, sof_pending, counters, overflow_o, line_width_o and line_count_o, set state RUN, and drive m_axis_tvalid=0.
REQ-036 SHALL, on reset mid-frame, emit no further output until a FIFO write occurs after rst_n_i rises; a partial frame without tuser is permitted.

Verification
REQ-037 Check: frame of 4 lines x 8 pixels, tready=1, ce_i=1 -> 32 beats, tuser only on beat 0, tlast on beats 7/15/23/31, line_width_o=8, line_count_o=4.
REQ-038 Check: ce_i toggling 1/0 on active cycles, 16 active cycles per line -> 8 pixels per line, line_width_o=8.
REQ-039 Check: tready=0 for a full 32-pixel line with FIFO_DEPTH=16 -> 16 beats retained, overflow_o=1, no further beats in that frame, next frame starts with tuser=1.
REQ-040 Check: tready toggled pseudo-randomly -> beat sequence matches input order, no loss, tdata stable while stalled.
REQ-041 Check: rst_n_i pulsed low mid-line -> tvalid=0 asynchronously, overflow_o=0, outputs zero, next frame correct.
REQ-042 Check: line end and vs_i rising in the same cycle -> that line counted in line_count_o, and its last pixel carries tlast=1.

Source files
------------

// File: rtl/cmos_axis_pack.sv
// ---------------------------------------------------------------------------
// cmos_axis_pack
//
// Packs a decoded CMOS pixel stream (hs/vs/ce qualified RGB565) into an
// AXI4-Stream video interface. A one-entry hold register delays each pixel
// until the next pixel or the end of the line is seen, so that tlast can be
// attached to the final pixel of every line. Frame start is marked with tuser
// on the first pixel. Beats are buffered in a small FIFO; if the FIFO cannot
// accept a beat, the rest of the frame is dropped and a sticky overflow flag
// is raised. Line width and line count of the most recently completed
// line/frame are measured continuously.
//
// Parameters
//   FIFO_DEPTH    output FIFO entries (power of two, 4..64)
//   WIDTH_BITS    width of the pixel and line counters
//
// Ports
//   cmos_pclk_i   pixel clock, all logic on rising edge
//   rst_n_i       asynchronous active-low reset
//   hs_i          line-active strobe
//   vs_i          frame sync, high during vertical blanking
//   rgb565_i      pixel data
//   ce_i          pixel-qualify enable
//   m_axis_*      AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   overflow_o    sticky FIFO overflow flag
//   line_width_o  pixel count of the last completed line
//   line_count_o  line count of the last completed frame
// ---------------------------------------------------------------------------
module cmos_axis_pack #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WIDTH_BITS = 12
) (
    input  logic                  cmos_pclk_i,
    input  logic                  rst_n_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic [15:0]           rgb565_i,
    input  logic                  ce_i,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  overflow_o,
    output logic [WIDTH_BITS-1:0] line_width_o,
    output logic [WIDTH_BITS-1:0] line_count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   run_active;

    // Sync delay registers and derived events
    logic hs_d;
    logic vs_d;
    logic pix_ev;
    logic line_end;
    logic frame_start;
    logic frame_end;

    // Hold register
    logic [15:0] hold_data;
    logic        hold_sof;
    logic        hold_valid;
    logic        sof_pending;

    // Push request towards the FIFO
    logic        push_req;
    logic        push_last;
    logic        wr_en;
    logic        reject;
    logic        take_pix;

    // FIFO storage: {sof, last, data}
    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [17:0]   head;
    logic          pop;
    logic          full;

    // Geometry counters
    logic [WIDTH_BITS-1:0] pix_cnt;
    logic [WIDTH_BITS-1:0] line_cnt;
    logic [WIDTH_BITS-1:0] line_cnt_upd;
    logic                  line_inc;

    // -----------------------------------------------------------------------
    // Event detection
    // -----------------------------------------------------------------------
    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hs_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            hs_d <= hs_i;
            vs_d <= vs_i;
        end
    end

    assign pix_ev      = ce_i & hs_i;
    assign line_end    = hs_d & ~hs_i;
    assign frame_start = vs_d & ~vs_i;
    assign frame_end   = ~vs_d & vs_i;

    // -----------------------------------------------------------------------
    // FIFO status
    // -----------------------------------------------------------------------
    assign m_axis_tvalid = (count != '0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign full          = (count == FULL_CNT);
    assign head          = mem[rd_ptr];

    // Outputs are forced to zero while the FIFO is empty so that a reset
    // leaves the bus quiet regardless of stale storage contents.
    assign m_axis_tdata = m_axis_tvalid ? head[15:0] : '0;
    assign m_axis_tlast = m_axis_tvalid & head[16];
    assign m_axis_tuser = m_axis_tvalid & head[17];

    // -----------------------------------------------------------------------
    // Push decision. Frame start has priority: a pixel still held when a new
    // frame begins belongs to no complete line and is discarded.
    // -----------------------------------------------------------------------
    always_comb begin
        push_req  = 1'b0;
        push_last = 1'b0;
        if (run_active && !frame_start && hold_valid) begin
            if (line_end) begin
                push_req  = 1'b1;
                push_last = 1'b1;
            end else if (pix_ev) begin
                push_req  = 1'b1;
            end
        end
    end

    assign wr_en    = push_req & (~full | pop);
    assign reject   = push_req & full & ~pop;
    assign take_pix = pix_ev & run_active & ~reject;

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (reject)      state_nxt = DROP;
            DROP:    if (frame_start) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        run_active = (state == RUN);
    end

    // -----------------------------------------------------------------------
    // Hold register and start-of-frame tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_data  <= '0;
            hold_sof   <= 1'b0;
            hold_valid <= 1'b0;
        end else if (!run_active || reject) begin
            hold_valid <= 1'b0;
            hold_sof   <= 1'b0;
        end else if (pix_ev) begin
            hold_valid <= 1'b1;
            hold_data  <= rgb565_i;
            hold_sof   <= sof_pending | frame_start;
        end else if (frame_start || line_end) begin
            hold_valid <= 1'b0;
        end
    end

    // sof_pending survives a dropped frame tail so the next accepted pixel
    // after frame start is always tagged.
    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sof_pending <= 1'b0;
        end else if (take_pix) begin
            sof_pending <= 1'b0;
        end else if (frame_start) begin
            sof_pending <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge cmos_pclk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= {hold_sof, push_last, hold_data};
        end
    end

    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
        end else if (reject) begin
            overflow_o <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Geometry measurement, independent of RUN/DROP
    // -----------------------------------------------------------------------
    assign line_inc     = line_end & (pix_cnt != '0);
    assign line_cnt_upd = (line_inc && (line_cnt != '1)) ? line_cnt + WIDTH_BITS'(1)
                                                         : line_cnt;

    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_cnt <= '0;
        end else if (line_end) begin
            pix_cnt <= '0;
        end else if (frame_start) begin
            pix_cnt <= pix_ev ? WIDTH_BITS'(1) : '0;
        end else if (pix_ev && (pix_cnt != '1)) begin
            pix_cnt <= pix_cnt + WIDTH_BITS'(1);
        end
    end

    // A line ending in the same cycle as the frame is folded into the
    // reported count via line_cnt_upd.
    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_cnt     <= '0;
            line_width_o <= '0;
            line_count_o <= '0;
        end else begin
            if (line_inc) begin
                line_width_o <= pix_cnt;
            end
            if (frame_end) begin
                line_count_o <= line_cnt_upd;
                line_cnt     <= '0;
            end else begin
                line_cnt     <= line_cnt_upd;
            end
        end
    end

endmodule

// File: tb/tb_cmos_axis_pack.sv
// ---------------------------------------------------------------------------
// tb_cmos_axis_pack
//
// Directed bench for cmos_axis_pack (FIFO_DEPTH=16, WIDTH_BITS=12).
// Pixel data of line l, pixel p is {l[7:0], p[7:0]}. Inputs change 1 ns
// after the rising edge, tready 2 ns after it, and the stream is sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_cmos_axis_pack;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        hs     = 1'b0;
    logic        vs     = 1'b1;
    logic        ce     = 1'b0;
    logic [15:0] rgb    = '0;
    logic        tready = 1'b0;

    logic [15:0] tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;
    logic        overflow;
    logic [11:0] line_width;
    logic [11:0] line_count;

    int checks     = 0;
    int errors     = 0;
    int stall_viol = 0;
    int mode       = 1;     // tready: 0 low, 1 high, 2 random
    int base       = 0;

    logic [17:0] q [$];     // captured beats {tuser, tlast, tdata}
    logic        prev_stall = 1'b0;
    logic [17:0] prev_head  = '0;

    cmos_axis_pack #(
        .FIFO_DEPTH (16),
        .WIDTH_BITS (12)
    ) dut (
        .cmos_pclk_i   (clk),
        .rst_n_i       (rst_n),
        .hs_i          (hs),
        .vs_i          (vs),
        .rgb565_i      (rgb),
        .ce_i          (ce),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .overflow_o    (overflow),
        .line_width_o  (line_width),
        .line_count_o  (line_count)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        case (mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (prev_stall && tvalid && ({tuser, tlast, tdata} !== prev_head))
            stall_viol++;
        prev_stall = tvalid && !tready;
        prev_head  = {tuser, tlast, tdata};
        if (tvalid && tready)
            q.push_back({tuser, tlast, tdata});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: blanking, frame start, lines of npix pixels, frame end.
    // toggle: ce alternates 1/0 over 2*npix active cycles.
    // last_vs: vs rises in the same cycle hs falls after the final line.
    task automatic frame(input int nlines, input int npix, input int gap,
                         input bit toggle, input bit last_vs);
        int ncyc;
        int p;
        hs = 1'b0; ce = 1'b0; vs = 1'b1;
        repeat (3) cyc();
        vs = 1'b0;
        repeat (3) cyc();
        for (int l = 0; l < nlines; l++) begin
            ncyc = toggle ? 2 * npix : npix;
            p = 0;
            for (int k = 0; k < ncyc; k++) begin
                hs = 1'b1;
                ce = toggle ? (k % 2 == 0) : 1'b1;
                if (ce) begin
                    rgb = 16'((l << 8) | p);
                    p++;
                end else begin
                    rgb = 16'hDEAD;
                end
                cyc();
            end
            hs = 1'b0;
            ce = 1'b0;
            if (last_vs && (l == nlines - 1)) begin
                vs = 1'b1;
                cyc();
            end else begin
                repeat (gap) cyc();
            end
        end
        vs = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic check_beats(input int n, input int npix, input bit last_en);
        logic [17:0] beat;
        chk("beat_count", 32'(q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < q.size()) begin
                beat = q[base + i];
                chk($sformatf("beat%0d_data", i), {16'h0, beat[15:0]},
                    32'(((i / npix) << 8) | (i % npix)));
                chk($sformatf("beat%0d_tuser", i), {31'h0, beat[17]}, 32'(i == 0));
                chk($sformatf("beat%0d_tlast", i), {31'h0, beat[16]},
                    32'(last_en && (i % npix == npix - 1)));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_tvalid_low", {31'h0, tvalid}, 0);
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("rst_tvalid", {31'h0, tvalid}, 0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        chk("rst_line_width", {20'h0, line_width}, 0);
        chk("rst_line_count", {20'h0, line_count}, 0);

        // 4 lines x 8 pixels, tready high
        base = q.size();
        frame(4, 8, 4, 1'b0, 1'b0);
        repeat (40) cyc();
        check_beats(32, 8, 1'b1);
        chk("f1_line_width", {20'h0, line_width}, 8);
        chk("f1_line_count", {20'h0, line_count}, 4);
        chk("f1_overflow", {31'h0, overflow}, 0);

        // ce toggling: 16 active cycles -> 8 pixels per line
        base = q.size();
        frame(2, 8, 4, 1'b1, 1'b0);
        repeat (40) cyc();
        check_beats(16, 8, 1'b1);
        chk("ce_line_width", {20'h0, line_width}, 8);
        chk("ce_line_count", {20'h0, line_count}, 2);

        // Overflow: 32-pixel line with sink stalled
        mode = 0;
        repeat (2) cyc();
        base = q.size();
        frame(1, 32, 4, 1'b0, 1'b0);
        repeat (5) cyc();
        chk("ovf_no_beats", 32'(q.size() - base), 0);
        chk("ovf_tvalid", {31'h0, tvalid}, 1);
        chk("ovf_flag", {31'h0, overflow}, 1);
        chk("ovf_line_width", {20'h0, line_width}, 32);
        chk("ovf_line_count", {20'h0, line_count}, 1);
        mode = 1;
        repeat (40) cyc();
        check_beats(16, 16, 1'b0);
        chk("ovf_drained", {31'h0, tvalid}, 0);
        base = q.size();
        frame(1, 4, 4, 1'b0, 1'b0);
        repeat (30) cyc();
        check_beats(4, 4, 1'b1);
        chk("ovf_sticky", {31'h0, overflow}, 1);

        // Reset pulse mid-line with beats pending
        mode = 0;
        base = q.size();
        hs = 1'b0; ce = 1'b0; vs = 1'b1;
        repeat (2) cyc();
        vs = 1'b0;
        repeat (3) cyc();
        for (int p = 0; p < 4; p++) begin
            hs = 1'b1; ce = 1'b1; rgb = 16'(16'h0A00 | p);
            cyc();
        end
        ce = 1'b0;
        repeat (2) cyc();
        chk("mid_tvalid", {31'h0, tvalid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", {31'h0, tvalid}, 0);
        chk("arst_overflow", {31'h0, overflow}, 0);
        chk("arst_tdata", {16'h0, tdata}, 0);
        chk("arst_tuser", {31'h0, tuser}, 0);
        chk("arst_tlast", {31'h0, tlast}, 0);
        chk("arst_line_width", {20'h0, line_width}, 0);
        chk("arst_line_count", {20'h0, line_count}, 0);
        hs = 1'b0; vs = 1'b1;
        cyc();
        rst_n = 1'b1;
        mode = 1;
        repeat (3) cyc();
        chk("arst_no_beats", 32'(q.size() - base), 0);
        frame(2, 6, 4, 1'b0, 1'b0);
        repeat (30) cyc();
        check_beats(12, 6, 1'b1);
        chk("arst_f_line_width", {20'h0, line_width}, 6);
        chk("arst_f_line_count", {20'h0, line_count}, 2);

        // Random back-pressure
        base = q.size();
        mode = 2;
        frame(3, 8, 20, 1'b0, 1'b0);
        mode = 1;
        repeat (40) cyc();
        check_beats(24, 8, 1'b1);
        chk("rnd_stall_stable", 32'(stall_viol), 0);
        chk("rnd_overflow", {31'h0, overflow}, 0);
        chk("rnd_line_count", {20'h0, line_count}, 3);

        // Line end coincident with frame end
        base = q.size();
        frame(2, 5, 4, 1'b0, 1'b1);
        repeat (30) cyc();
        check_beats(10, 5, 1'b1);
        chk("coinc_line_width", {20'h0, line_width}, 5);
        chk("coinc_line_count", {20'h0, line_count}, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
